// File: rtl/traffic_lights_pkg.sv
// traffic_lights_pkg: command and request encodings shared by the traffic-light controller and its command master.
package traffic_lights_pkg;
    localparam int CMD_SIZE = 3;
    localparam int PERIOD_SIZE = 16;
    typedef enum logic [CMD_SIZE-1:0] {
        CMD_ON           = 3'd0,
        CMD_OFF          = 3'd1,
        CMD_NOTRANSITION = 3'd2,
        CMD_SET_GREEN    = 3'd3,
        CMD_SET_RED      = 3'd4,
        CMD_SET_YELLOW   = 3'd5
    } cmd_e;
    typedef enum logic [1:0] {OP_RECONFIG, OP_OFF, OP_ON, OP_RSVD} op_e;
    // Reconfigure walks steps 0..4 as NOTRANSITION, SET_GREEN, SET_RED, SET_YELLOW, ON.
    function automatic cmd_e seq_cmd(op_e op, logic [2:0] step);
        return (op == OP_OFF) ? CMD_OFF : (op == OP_ON || step == 3'd4) ? CMD_ON : cmd_e'(step + 3'd2);
    endfunction
endpackage

// File: rtl/traffic_lights_cmd_master.sv
// traffic_lights_cmd_master: expands host requests into ordered, gap-spaced controller commands.
// Define SKIP_UNCHANGED_EN to drop SET_x commands whose period equals the last one issued.
module traffic_lights_cmd_master #(
    parameter int CMD_GAP = 1,
    parameter int PERIOD_SIZE = traffic_lights_pkg::PERIOD_SIZE,
    parameter int CMD_SIZE = traffic_lights_pkg::CMD_SIZE
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_op_i,
    input  logic [PERIOD_SIZE-1:0] req_green_i,
    input  logic [PERIOD_SIZE-1:0] req_red_i,
    input  logic [PERIOD_SIZE-1:0] req_yellow_i,
    output logic [CMD_SIZE-1:0]    cmd_type_o,
    output logic                   cmd_valid_o,
    output logic [PERIOD_SIZE-1:0] cmd_data_o,
    output logic                   busy_o,
    output logic                   err_o
);
    import traffic_lights_pkg::*;
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;
    localparam int GW = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;
    state_e state, state_n;
    logic [2:0] step, step_n, nxt_step;
    logic [GW-1:0] gap_cnt, gap_n;
    op_e op_q, op_sel;
    logic [PERIOD_SIZE-1:0] green_q, red_q, yellow_q, data_n;
    logic [3:1] skip;
    cmd_e cmd_n;
    logic accept, bad, last;

    assign req_ready_o = state == IDLE;
    assign busy_o = state != IDLE;
    assign accept = req_valid_i && req_ready_o;
    assign bad = req_op_i == 2'd3 ||
                 (req_op_i == 2'd0 && (req_green_i == '0 || req_red_i == '0 || req_yellow_i == '0));
    assign last = op_q != OP_RECONFIG || step == 3'd4;
    // The first command is registered at the accept edge, before op_q is loaded.
    assign op_sel = (state == IDLE) ? op_e'(req_op_i) : op_q;
    assign cmd_n = seq_cmd(op_sel, step_n);
    assign data_n = (cmd_n == CMD_SET_GREEN) ? green_q :
                    (cmd_n == CMD_SET_RED) ? red_q :
                    (cmd_n == CMD_SET_YELLOW) ? yellow_q : '0;

`ifdef SKIP_UNCHANGED_EN
    logic [PERIOD_SIZE-1:0] sh_green, sh_red, sh_yellow;
    logic [2:0] sh_vld;
    assign skip = {sh_vld[2] && sh_yellow == yellow_q, sh_vld[1] && sh_red == red_q, sh_vld[0] && sh_green == green_q};
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sh_vld <= '0;
        end else if (state_n == ISSUE) begin
            if (cmd_n == CMD_SET_GREEN) begin
                sh_green <= green_q;
                sh_vld[0] <= 1'b1;
            end
            if (cmd_n == CMD_SET_RED) begin
                sh_red <= red_q;
                sh_vld[1] <= 1'b1;
            end
            if (cmd_n == CMD_SET_YELLOW) begin
                sh_yellow <= yellow_q;
                sh_vld[2] <= 1'b1;
            end
        end
    end
`else
    assign skip = '0;
`endif

    // Lowest unskipped SET step after the current one; ON (step 4) is never skipped.
    always_comb begin
        nxt_step = 3'd4;
        for (int i = 3; i >= 1; i--)
            if (i > int'(step) && !skip[i]) nxt_step = 3'(i);
    end

    always_comb begin
        state_n = state;
        step_n = step;
        gap_n = gap_cnt;
        case (state)
            IDLE: begin
                if (accept && !bad) begin
                    state_n = ISSUE;
                    step_n = '0;
                end
            end
            ISSUE: begin
                if (CMD_GAP > 0) begin
                    state_n = GAP;
                    gap_n = GW'(1);
                end else if (last) begin
                    state_n = IDLE;
                end else begin
                    step_n = nxt_step;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(CMD_GAP)) begin
                    state_n = last ? IDLE : ISSUE;
                    step_n = last ? step : nxt_step;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state <= IDLE;
            step <= '0;
            gap_cnt <= '0;
            op_q <= OP_RECONFIG;
            green_q <= '0;
            red_q <= '0;
            yellow_q <= '0;
            cmd_valid_o <= 1'b0;
            cmd_type_o <= '0;
            cmd_data_o <= '0;
            err_o <= 1'b0;
        end else begin
            state <= state_n;
            step <= step_n;
            gap_cnt <= gap_n;
            err_o <= accept && bad;
            cmd_valid_o <= state_n == ISSUE;
            if (accept) begin
                op_q <= op_e'(req_op_i);
                green_q <= req_green_i;
                red_q <= req_red_i;
                yellow_q <= req_yellow_i;
            end
            if (state_n == ISSUE) begin
                cmd_type_o <= CMD_SIZE'(cmd_n);
                cmd_data_o <= data_n;
            end
        end
    end
endmodule
